// File: rtl/csr_wo_pulse_bank.sv
// csr_wo_pulse_bank: bank of write-only CSRs mixing held bits and
// self-clearing pulse bits; reads always return zero.
module csr_wo_pulse_bank #(
  parameter int unsigned       ADDR_W        = 16,
  parameter int unsigned       DATA_W        = 32,
  parameter int unsigned       STRB_W        = DATA_W / 8,
  parameter int unsigned       NUM_REGS      = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 'h30,
  parameter logic [DATA_W-1:0] PULSE_MASK    = 'h1,
  parameter int unsigned       PULSE_LEN     = 1,
  parameter bit                BLOCK_ON_BUSY = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            lb_waddr,
  input  logic [DATA_W-1:0]            lb_wdata,
  input  logic                         lb_wen,
  input  logic [STRB_W-1:0]            lb_wstrb,
  output logic                         lb_wready,
  input  logic [ADDR_W-1:0]            lb_raddr,
  input  logic                         lb_ren,
  output logic [DATA_W-1:0]            lb_rdata,
  output logic                         lb_rvalid,
  output logic [NUM_REGS*DATA_W-1:0]   csr_val_out,
  output logic [NUM_REGS*DATA_W-1:0]   csr_pulse_out,
  output logic [NUM_REGS-1:0]          csr_wstb_out,
  output logic [NUM_REGS-1:0]          csr_busy_out
);

  localparam logic [7:0] PL = 8'(PULSE_LEN);

  logic [DATA_W-1:0]   w_bm;
  logic [NUM_REGS-1:0] w_hit;
  logic [NUM_REGS-1:0] w_blk;
  logic [NUM_REGS-1:0] w_acc;
  logic                r_rvalid;
  logic                w_unused;

  always_comb begin
    w_bm = '0;
    for (int b = 0; b < int'(STRB_W); b++) begin
      w_bm[b*8 +: 8] = {8{lb_wstrb[b]}};
    end
  end

  assign lb_wready = !(BLOCK_ON_BUSY && (|w_blk));

  for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_reg
    localparam logic [ADDR_W-1:0] LA =
      BASE_ADDR + ADDR_W'(i * STRB_W);

    logic [DATA_W-1:0] r_val;
    logic [DATA_W-1:0] r_pul;
    logic [DATA_W-1:0] w_vnew;
    logic [DATA_W-1:0] w_pnew;
    logic [DATA_W-1:0] w_pnxt;
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnxt;
    logic              r_wstb;
    logic              r_busy;

    assign w_hit[i] = (lb_waddr == LA);
    assign w_blk[i] = w_hit[i] && (r_cnt != 8'd0);
    assign w_acc[i] = lb_wen && lb_wready && w_hit[i];

    assign w_vnew = (r_val & ~w_bm)
                  | (lb_wdata & ~PULSE_MASK & w_bm);
    assign w_pnew = (r_pul & ~w_bm)
                  | (lb_wdata & PULSE_MASK & w_bm);

    // A write landing on the expiry edge wins and reloads.
    always_comb begin
      w_pnxt = r_pul;
      w_cnxt = r_cnt;
      if (w_acc[i]) begin
        w_pnxt = w_pnew;
        if (|w_pnew) begin
          w_cnxt = PL;
        end
      end else if (r_cnt > 8'd1) begin
        w_cnxt = r_cnt - 8'd1;
      end else if (r_cnt == 8'd1) begin
        w_pnxt = '0;
        w_cnxt = 8'd0;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_val  <= '0;
        r_pul  <= '0;
        r_cnt  <= 8'd0;
        r_wstb <= 1'b0;
        r_busy <= 1'b0;
      end else begin
        if (w_acc[i]) begin
          r_val <= w_vnew;
        end
        r_pul  <= w_pnxt;
        r_cnt  <= w_cnxt;
        r_wstb <= w_acc[i];
        r_busy <= (w_cnxt != 8'd0);
      end
    end

    assign csr_val_out[i*DATA_W +: DATA_W]   = r_val;
    assign csr_pulse_out[i*DATA_W +: DATA_W] = r_pul;
    assign csr_wstb_out[i]                   = r_wstb;
    assign csr_busy_out[i]                   = r_busy;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= lb_ren;
    end
  end

  assign lb_rvalid = r_rvalid;
  assign lb_rdata  = '0;
  assign w_unused  = ^lb_raddr;

endmodule

// File: tb/tb_csr_wo_pulse_bank.sv
// tb_csr_wo_pulse_bank: three configurations share one stimulus stream;
// a reference model queues expected outputs, a monitor pops and compares.
module tb_csr_wo_pulse_bank;

  localparam int ND = 3;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [15:0] waddr;
  logic [15:0] raddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wen;
  logic        ren;

  logic [ND-1:0] wready;
  logic [ND-1:0] rvalid;
  logic [31:0]   rdata [ND];
  logic [127:0]  val   [ND];
  logic [127:0]  pul   [ND];
  logic [3:0]    wstb  [ND];
  logic [3:0]    busy  [ND];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  csr_wo_pulse_bank #(.PULSE_LEN(3), .BLOCK_ON_BUSY(1'b0)) u_d0 (
    .clk(clk), .rst(rst),
    .lb_waddr(waddr), .lb_wdata(wdata), .lb_wen(wen),
    .lb_wstrb(wstrb), .lb_wready(wready[0]),
    .lb_raddr(raddr), .lb_ren(ren),
    .lb_rdata(rdata[0]), .lb_rvalid(rvalid[0]),
    .csr_val_out(val[0]), .csr_pulse_out(pul[0]),
    .csr_wstb_out(wstb[0]), .csr_busy_out(busy[0])
  );

  csr_wo_pulse_bank #(.PULSE_LEN(4), .BLOCK_ON_BUSY(1'b0)) u_d1 (
    .clk(clk), .rst(rst),
    .lb_waddr(waddr), .lb_wdata(wdata), .lb_wen(wen),
    .lb_wstrb(wstrb), .lb_wready(wready[1]),
    .lb_raddr(raddr), .lb_ren(ren),
    .lb_rdata(rdata[1]), .lb_rvalid(rvalid[1]),
    .csr_val_out(val[1]), .csr_pulse_out(pul[1]),
    .csr_wstb_out(wstb[1]), .csr_busy_out(busy[1])
  );

  csr_wo_pulse_bank #(.PULSE_LEN(4), .BLOCK_ON_BUSY(1'b1)) u_d2 (
    .clk(clk), .rst(rst),
    .lb_waddr(waddr), .lb_wdata(wdata), .lb_wen(wen),
    .lb_wstrb(wstrb), .lb_wready(wready[2]),
    .lb_raddr(raddr), .lb_ren(ren),
    .lb_rdata(rdata[2]), .lb_rvalid(rvalid[2]),
    .csr_val_out(val[2]), .csr_pulse_out(pul[2]),
    .csr_wstb_out(wstb[2]), .csr_busy_out(busy[2])
  );

  typedef struct packed {
    logic [ND-1:0][127:0] val;
    logic [ND-1:0][127:0] pul;
    logic [ND-1:0][3:0]   wstb;
    logic [ND-1:0][3:0]   busy;
    logic                 rvalid;
  } snap_t;

  snap_t sq[$];

  logic [31:0] m_val [ND][NR];
  logic [31:0] m_pul [ND][NR];
  int          m_cnt [ND][NR];

  function automatic int plen(int d);
    return (d == 0) ? 3 : 4;
  endfunction

  function automatic bit blk(int d);
    return d == 2;
  endfunction

  function automatic int reg_idx(logic [15:0] a);
    if (a >= 16'h30 && a < 16'h40 && a[1:0] == 2'b00)
      return int'((a - 16'h30) >> 2);
    return -1;
  endfunction

  function automatic bit exp_ready(int d);
    int idx;
    idx = reg_idx(waddr);
    return !(blk(d) && idx >= 0 && m_cnt[d][idx] != 0);
  endfunction

  task automatic chk(string nm, int d, logic [127:0] act,
                     logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%h want=%h",
               nm, d, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < NR; i++) begin
        m_val[d][i] = '0;
        m_pul[d][i] = '0;
        m_cnt[d][i] = 0;
      end
  endtask

  task automatic model_step(output snap_t s);
    int          idx;
    bit          rdy;
    logic [31:0] np;
    logic [31:0] pm;
    pm = 32'h1;
    s = '0;
    s.rvalid = ren;
    idx = reg_idx(waddr);
    for (int d = 0; d < ND; d++) begin
      rdy = exp_ready(d);
      for (int i = 0; i < NR; i++) begin
        if (wen && rdy && idx == i) begin
          np = m_pul[d][i];
          for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
              m_val[d][i][b*8 +: 8] = wdata[b*8 +: 8] & ~pm[b*8 +: 8];
              np[b*8 +: 8] = wdata[b*8 +: 8] & pm[b*8 +: 8];
            end
          end
          m_pul[d][i] = np;
          if (np != 0) m_cnt[d][i] = plen(d);
          s.wstb[d][i] = 1'b1;
        end else if (m_cnt[d][i] > 1) begin
          m_cnt[d][i] = m_cnt[d][i] - 1;
        end else if (m_cnt[d][i] == 1) begin
          m_cnt[d][i] = 0;
          m_pul[d][i] = '0;
        end
        s.val[d][i*32 +: 32] = m_val[d][i];
        s.pul[d][i*32 +: 32] = m_pul[d][i];
        s.busy[d][i] = (m_cnt[d][i] != 0);
      end
    end
  endtask

  always @(posedge clk) begin : p_model
    snap_t s;
    if (!rst) begin
      model_reset();
      s = '0;
    end else begin
      model_step(s);
    end
    sq.push_back(s);
  end

  always begin : p_monitor
    snap_t e;
    @(posedge clk);
    #1;
    if (sq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty t=%0t got=0 want=1", $time);
    end else begin
      e = sq.pop_front();
      for (int d = 0; d < ND; d++) begin
        chk("val", d, val[d], e.val[d]);
        chk("pulse", d, pul[d], e.pul[d]);
        chk("wstb", d, wstb[d], e.wstb[d]);
        chk("busy", d, busy[d], e.busy[d]);
        chk("rvalid", d, rvalid[d], e.rvalid);
        if (rvalid[d]) chk("rdata", d, rdata[d], 0);
      end
    end
  end

  always begin : p_ready
    @(negedge clk);
    #2;
    if (rst) begin
      for (int d = 0; d < ND; d++)
        chk("wready", d, wready[d], exp_ready(d));
    end
  end

  task automatic chk_zero();
    for (int d = 0; d < ND; d++) begin
      chk("rst_val", d, val[d], 0);
      chk("rst_pulse", d, pul[d], 0);
      chk("rst_wstb", d, wstb[d], 0);
      chk("rst_busy", d, busy[d], 0);
      chk("rst_rvalid", d, rvalid[d], 0);
      chk("rst_rdata", d, rdata[d], 0);
    end
  endtask

  task automatic cyc(bit we, logic [15:0] wa, logic [31:0] wd,
                     logic [3:0] ws, bit re, logic [15:0] ra);
    @(negedge clk);
    wen   = we;
    waddr = wa;
    wdata = wd;
    wstrb = ws;
    ren   = re;
    raddr = ra;
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 16'h0);
  endtask

  function automatic logic [15:0] rnd_addr();
    case ($urandom_range(0, 7))
      0: return 16'h30;
      1: return 16'h34;
      2: return 16'h38;
      3: return 16'h3c;
      4: return 16'h40;
      5: return 16'h31;
      6: return 16'h80;
      default: return 16'h2c;
    endcase
  endfunction

  initial begin : p_stim
    int n;
    bit acc;
    wen = 0; ren = 0; waddr = 0; raddr = 0; wdata = 0; wstrb = 0;
    #1 rst = 1'b0;
    #1 chk_zero();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    cyc(1, 16'h30, 32'hdeadbeef, 4'hf, 0, 16'h0);
    cyc(0, 16'h0, 32'h0, 4'h0, 1, 16'h30);
    cyc(0, 16'h0, 32'h0, 4'h0, 1, 16'h80);
    idle(2);
    cyc(1, 16'h34, 32'h1, 4'hf, 0, 16'h0);
    idle(6);
    cyc(1, 16'h38, 32'hffffffff, 4'h4, 1, 16'h38);
    idle(2);

    cyc(1, 16'h30, 32'h1, 4'h1, 0, 16'h0);
    idle(2);
    n = 0;
    acc = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      wen = 1; waddr = 16'h30; wdata = 32'h1; wstrb = 4'h1; ren = 0;
      #1 acc = wready[2];
      n++;
    end
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL block_accept got=0 want=1 after %0d cycles", n);
    end
    idle(8);

    repeat (400) begin
      cyc(1'($urandom_range(0, 1)), rnd_addr(), $urandom,
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
          rnd_addr());
    end
    idle(6);

    cyc(1, 16'h30, 32'h1, 4'h1, 0, 16'h0);
    cyc(1, 16'h34, 32'h5, 4'hf, 1, 16'h34);
    idle(1);
    @(negedge clk);
    #3 rst = 1'b0;
    #1 chk_zero();
    @(negedge clk);
    rst = 1'b1;
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
